// File: rtl/alu_decoder_mc.sv
// Registered RV32 ALU-op decoder; MUL/DIV ops are held for a programmable latency
// while the core is stalled. Single-cycle ops: 1-cycle latency, back-to-back accept.
module alu_decoder_mc #(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_WIDTH  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic       addr_calc,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       alu_valid,
  output logic       illegal,
  output logic       stall
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,   OP_XOR = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_SLL = 4'd5,   OP_SRL = 4'd6,  OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8,  OP_SRA = 4'd9,   OP_SLT = 4'd10, OP_SLTU = 4'd11;
  localparam logic [3:0] OP_LUI = 4'd12, OP_REM = 4'd13,  OP_DIVU = 4'd14, OP_NA = 4'd15;

  localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [3:0]           alu_op_nxt, dec_op;
  logic                 alu_valid_nxt, illegal_nxt;
  logic                 dec_illegal, dec_mul, dec_div, dec_multi;

  assign issue_ready = (state == IDLE);
  assign stall       = (state == BUSY);

  // OP_NA is never a legal result, so illegality falls out of the decoded op.
  always_comb begin
    dec_op  = OP_NA;
    dec_mul = 1'b0;
    dec_div = 1'b0;
    if (addr_calc) begin
      dec_op = OP_ADD;
    end else begin
      case (opcode)
        7'b0110011: begin
          if (funct7 == 7'b0000001) begin
            if (ENABLE_M) begin
              case (funct3)
                3'b000: begin dec_op = OP_MUL;  dec_mul = 1'b1; end
                3'b100: begin dec_op = OP_DIV;  dec_div = 1'b1; end
                3'b101: begin dec_op = OP_DIVU; dec_div = 1'b1; end
                3'b110: begin dec_op = OP_REM;  dec_div = 1'b1; end
                default: dec_op = OP_NA;
              endcase
            end
          end else if (funct7 == 7'b0000000) begin
            case (funct3)
              3'b000:  dec_op = OP_ADD;
              3'b001:  dec_op = OP_SLL;
              3'b010:  dec_op = OP_SLT;
              3'b011:  dec_op = OP_SLTU;
              3'b100:  dec_op = OP_XOR;
              3'b101:  dec_op = OP_SRL;
              3'b110:  dec_op = OP_OR;
              default: dec_op = OP_AND;
            endcase
          end else if (funct7 == 7'b0100000) begin
            if (funct3 == 3'b000)      dec_op = OP_SUB;
            else if (funct3 == 3'b101) dec_op = OP_SRA;
          end
        end
        7'b0010011: begin
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b110:  dec_op = OP_OR;
            3'b111:  dec_op = OP_AND;
            3'b001:  if (funct7 == 7'b0000000) dec_op = OP_SLL;
            default: begin
              if (funct7 == 7'b0000000)      dec_op = OP_SRL;
              else if (funct7 == 7'b0100000) dec_op = OP_SRA;
            end
          endcase
        end
        7'b0000011, 7'b0100011: if (funct3 == 3'b010) dec_op = OP_ADD;
        7'b1100011: if (funct3 == 3'b000 || funct3 == 3'b001) dec_op = OP_ADD;
        7'b1100111: if (funct3 == 3'b000) dec_op = OP_ADD;
        7'b1101111, 7'b0010111: dec_op = OP_ADD;
        7'b0110111: dec_op = OP_LUI;
        default: dec_op = OP_NA;
      endcase
    end
  end

  assign dec_illegal = (dec_op == OP_NA);
  // A latency of 1 makes the op indistinguishable from a single-cycle one.
  assign dec_multi   = (dec_mul && (MUL_CYCLES > 1)) || (dec_div && (DIV_CYCLES > 1));

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    alu_op_nxt    = alu_op;
    illegal_nxt   = illegal;
    alu_valid_nxt = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            alu_op_nxt  = dec_op;
            illegal_nxt = dec_illegal;
            if (dec_multi) begin
              state_nxt = BUSY;
              cnt_nxt   = dec_mul ? MUL_LOAD : DIV_LOAD;
            end else begin
              alu_valid_nxt = 1'b1;
            end
          end
        end
        default: begin
          if (cnt == CNT_WIDTH'(1)) begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            alu_valid_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt - CNT_WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_op    <= OP_NA;
      alu_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      alu_op    <= alu_op_nxt;
      alu_valid <= alu_valid_nxt;
      illegal   <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_alu_decoder_mc.sv
// Directed bench for alu_decoder_mc: default instance plus an ENABLE_M=0 instance.
module tb_alu_decoder_mc;
  logic       clk = 1'b0;
  logic       rst, flush, issue_valid, addr_calc;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       issue_ready, alu_valid, illegal, stall;
  logic [3:0] alu_op;
  logic       n_issue_ready, n_alu_valid, n_illegal, n_stall;
  logic [3:0] n_alu_op;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_decoder_mc dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .addr_calc(addr_calc), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .alu_op(alu_op), .alu_valid(alu_valid),
    .illegal(illegal), .stall(stall)
  );

  alu_decoder_mc #(.ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(n_issue_ready), .addr_calc(addr_calc), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .alu_op(n_alu_op), .alu_valid(n_alu_valid),
    .illegal(n_illegal), .stall(n_stall)
  );

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ac, input logic [6:0] o,
                       input logic [2:0] f3, input logic [6:0] f7);
    issue_valid = v;
    addr_calc   = ac;
    opcode      = o;
    funct3      = f3;
    funct7      = f7;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 7'b0, 3'b0, 7'b0);
  endtask

  // Issue one single-cycle instruction and check the registered result.
  task automatic one(input string tag, input logic [6:0] o, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [3:0] exp_op, input logic exp_ill);
    drive(1'b1, 1'b0, o, f3, f7);
    tick();
    chk4({tag, "_op"}, alu_op, exp_op);
    chk1({tag, "_ill"}, illegal, exp_ill);
    chk1({tag, "_vld"}, alu_valid, 1'b1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    idle();
    tick(); tick();
    chk4("rst_op", alu_op, 4'd15);
    chk1("rst_vld", alu_valid, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_rdy", issue_ready, 1'b1);
    chk1("rst_ill", illegal, 1'b0);
    rst = 1'b0;

    one("addi", 7'b0010011, 3'b000, 7'b1010101, 4'd0, 1'b0);
    chk1("nom_addi_vld", n_alu_valid, 1'b1);
    one("slli_bad", 7'b0010011, 3'b001, 7'b0100000, 4'd15, 1'b1);
    one("srai", 7'b0010011, 3'b101, 7'b0100000, 4'd9, 1'b0);
    one("add", 7'b0110011, 3'b000, 7'b0000000, 4'd0, 1'b0);
    one("sub", 7'b0110011, 3'b000, 7'b0100000, 4'd1, 1'b0);
    idle();
    tick();
    chk1("idle_vld", alu_valid, 1'b0);
    chk4("idle_hold", alu_op, 4'd1);

    drive(1'b1, 1'b1, 7'b0000000, 3'b000, 7'b0000000);
    tick();
    chk4("acalc_op", alu_op, 4'd0);
    chk1("acalc_ill", illegal, 1'b0);
    chk1("acalc_vld", alu_valid, 1'b1);

    one("lui", 7'b0110111, 3'b111, 7'b1111111, 4'd12, 1'b0);
    one("sltu", 7'b0110011, 3'b011, 7'b0000000, 4'd11, 1'b0);
    one("bne", 7'b1100011, 3'b001, 7'b0000000, 4'd0, 1'b0);
    one("lw_bad", 7'b0000011, 3'b001, 7'b0000000, 4'd15, 1'b1);
    one("mulh_bad", 7'b0110011, 3'b001, 7'b0000001, 4'd15, 1'b1);
    one("sub_xor_bad", 7'b0110011, 3'b100, 7'b0100000, 4'd15, 1'b1);

    // mul: busy t+1..t+3, result at t+4; issue during BUSY must be ignored
    drive(1'b1, 1'b0, 7'b0110011, 3'b000, 7'b0000001);
    tick();
    chk4("mul_op_t1", alu_op, 4'd7);
    chk1("nom_mul_ill", n_illegal, 1'b1);
    chk4("nom_mul_op", n_alu_op, 4'd15);
    chk1("nom_mul_stall", n_stall, 1'b0);
    drive(1'b1, 1'b0, 7'b0110011, 3'b000, 7'b0000000);
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) tick();
      chk1("mul_stall", stall, 1'b1);
      chk1("mul_rdy", issue_ready, 1'b0);
      chk1("mul_vld_early", alu_valid, 1'b0);
      chk4("mul_op_hold", alu_op, 4'd7);
    end
    tick();
    idle();
    chk1("mul_vld", alu_valid, 1'b1);
    chk4("mul_op", alu_op, 4'd7);
    chk1("mul_ill", illegal, 1'b0);
    chk1("mul_stall_end", stall, 1'b0);
    tick();
    chk1("mul_vld_once", alu_valid, 1'b0);

    // div flushed at t+5
    drive(1'b1, 1'b0, 7'b0110011, 3'b100, 7'b0000001);
    tick();
    idle();
    chk4("div_op", alu_op, 4'd8);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      chk1("div_stall", stall, 1'b1);
      chk1("div_vld", alu_valid, 1'b0);
    end
    flush = 1'b1;
    drive(1'b1, 1'b0, 7'b0110011, 3'b000, 7'b0000000);
    tick();
    flush = 1'b0;
    idle();
    chk1("flush_stall", stall, 1'b0);
    chk1("flush_vld", alu_valid, 1'b0);
    chk1("flush_rdy", issue_ready, 1'b1);
    chk4("flush_op_hold", alu_op, 4'd8);
    flush = 1'b1;
    drive(1'b1, 1'b0, 7'b0110011, 3'b000, 7'b0100000);
    tick();
    flush = 1'b0;
    idle();
    chk1("flush_drop_vld", alu_valid, 1'b0);
    chk4("flush_drop_op", alu_op, 4'd8);

    drive(1'b1, 1'b0, 7'b0110011, 3'b101, 7'b0000001);
    tick();
    idle();
    chk4("divu_op", alu_op, 4'd14);
    chk1("divu_stall", stall, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("divu_flush_stall", stall, 1'b0);

    // reset mid-BUSY: no result pulse afterwards
    drive(1'b1, 1'b0, 7'b0110011, 3'b000, 7'b0000001);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk4("rstbusy_op", alu_op, 4'd15);
    chk1("rstbusy_stall", stall, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk1("rstbusy_vld", alu_valid, 1'b0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
